// File: rtl/gate_seq_pkg.sv
// gate_seq_pkg: shared widths and FSM state type for the gate truth-table sequencer
package gate_seq_pkg;
  localparam int NUM_VEC = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 4;
  localparam int ERR_W = 4;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
endpackage

// File: rtl/gate_truth_sequencer_if.sv
// gate_truth_sequencer_if: control, gate-vector and result signals between the board side and the sequencer
interface gate_truth_sequencer_if;
  import gate_seq_pkg::*;
  logic start;
  logic abort;
  logic dut_a;
  logic dut_b;
  logic dut_c;
  logic dut_f1;
  logic dut_f2;
  logic busy;
  logic done;
  logic pass;
  logic [ERR_W-1:0] err_count;
  logic fail_valid;
  logic [IDX_W-1:0] first_fail_idx;
  modport master (
    output start, abort, dut_f1, dut_f2,
    input dut_a, dut_b, dut_c, busy, done, pass, err_count, fail_valid, first_fail_idx
  );
  modport slave (
    input start, abort, dut_f1, dut_f2,
    output dut_a, dut_b, dut_c, busy, done, pass, err_count, fail_valid, first_fail_idx
  );
endinterface

// File: rtl/gate_seq_settle_timer.sv
// gate_seq_settle_timer: loadable down-counter with a zero flag used to time each vector's settle window
module gate_seq_settle_timer
  import gate_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : dec ? cnt_q - CNT_W'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign zero = cnt_q == '0;
endmodule

// File: rtl/gate_truth_sequencer.sv
// gate_truth_sequencer: sweeps all 8 {A,B,C} vectors into an external gate and checks F1/F2 against truth-table masks
module gate_truth_sequencer
  import gate_seq_pkg::*;
#(
  parameter int unsigned        SETTLE_CYCLES = 2,
  parameter logic [NUM_VEC-1:0] EXP_F2        = 8'h7F,
  parameter logic [NUM_VEC-1:0] EXP_F1        = 8'h00,
  parameter bit                 CHK_F1        = 1'b0
) (
  input logic                   clk,
  input logic                   rst_n,
  gate_truth_sequencer_if.slave bus
);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, ffi_q, ffi_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic fv_q, fv_d, pass_q, pass_d;
  logic load, dec, zero, miss, last;
  gate_seq_settle_timer u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .dec(dec),
    .load_val(RELOAD),
    .zero(zero)
  );
  assign miss = (bus.dut_f2 != EXP_F2[idx_q]) | (CHK_F1 & (bus.dut_f1 != EXP_F1[idx_q]));
  assign last = idx_q == IDX_W'(NUM_VEC - 1);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    err_d = err_q;
    fv_d = fv_q;
    ffi_d = ffi_q;
    pass_d = pass_q;
    load = 1'b0;
    dec = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      idx_d = '0;
      pass_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = SETTLE;
            idx_d = '0;
            load = 1'b1;
            err_d = '0;
            fv_d = 1'b0;
            ffi_d = '0;
            pass_d = 1'b0;
          end
        end
        SETTLE: begin
          state_d = zero ? SAMPLE : SETTLE;
          dec = !zero;
        end
        SAMPLE: begin
          err_d = err_q + ERR_W'(miss);
          fv_d = fv_q | miss;
          ffi_d = (miss && !fv_q) ? idx_q : ffi_q;
          state_d = last ? DONE : SETTLE;
          idx_d = last ? idx_q : idx_q + IDX_W'(1);
          load = !last;
          pass_d = last ? (err_d == '0) : pass_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      err_q <= '0;
      fv_q <= 1'b0;
      ffi_q <= '0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      err_q <= err_d;
      fv_q <= fv_d;
      ffi_q <= ffi_d;
      pass_q <= pass_d;
    end
  end
  assign {bus.dut_a, bus.dut_b, bus.dut_c} = idx_q;
  assign bus.busy = (state_q == SETTLE) || (state_q == SAMPLE);
  assign bus.done = state_q == DONE;
  assign bus.pass = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_valid = fv_q;
  assign bus.first_fail_idx = ffi_q;
endmodule

// File: tb/tb_gate_truth_sequencer.sv
// tb_gate_truth_sequencer: scoreboard bench driving gate models into two sequencer configurations
module tb_gate_truth_sequencer;
  import gate_seq_pkg::*;
  typedef struct packed {
    logic [ERR_W-1:0] err;
    logic             fv;
    logic [IDX_W-1:0] ffi;
    logic             pass;
  } res_t;
  localparam int SETTLE = 2;
  localparam int LAT = 8 * (SETTLE + 1) + 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_r = 1'b0;
  logic abort_r = 1'b0;
  logic sel = 1'b0;
  logic f1_stuck = 1'b0;
  logic [1:0] mode = 2'd0;
  int checks = 0;
  int errors = 0;
  res_t sb[$];
  logic [2:0] v0, v1, m_vec, m_ffi;
  logic [3:0] m_err;
  logic m_busy, m_done, m_pass, m_fv;
  logic [13:0] m_all;
  gate_truth_sequencer_if bus0 ();
  gate_truth_sequencer_if bus1 ();
  always #5 clk = ~clk;
  gate_truth_sequencer u_dut0 (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus0)
  );
  gate_truth_sequencer #(
    .SETTLE_CYCLES(SETTLE),
    .EXP_F2(8'h7F),
    .EXP_F1(8'h80),
    .CHK_F1(1'b1)
  ) u_dut1 (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus1)
  );
  assign v0 = {bus0.dut_a, bus0.dut_b, bus0.dut_c};
  assign v1 = {bus1.dut_a, bus1.dut_b, bus1.dut_c};
  assign bus0.start = start_r & ~sel;
  assign bus1.start = start_r & sel;
  assign bus0.abort = abort_r & ~sel;
  assign bus1.abort = abort_r & sel;
  assign bus0.dut_f1 = 1'b0;
  assign bus0.dut_f2 = (mode == 2'd1) ? &v0 : (mode == 2'd2 && v0 == 3'd5) ? 1'b0 : ~&v0;
  assign bus1.dut_f1 = f1_stuck ? 1'b0 : &v1;
  assign bus1.dut_f2 = ~&v1;
  assign m_vec = sel ? v1 : v0;
  assign m_busy = sel ? bus1.busy : bus0.busy;
  assign m_done = sel ? bus1.done : bus0.done;
  assign m_pass = sel ? bus1.pass : bus0.pass;
  assign m_err = sel ? bus1.err_count : bus0.err_count;
  assign m_fv = sel ? bus1.fail_valid : bus0.fail_valid;
  assign m_ffi = sel ? bus1.first_fail_idx : bus0.first_fail_idx;
  assign m_all = {m_busy, m_done, m_vec, m_pass, m_err, m_fv, m_ffi};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic score();
    res_t e;
    check("sb_pending", sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("err_count", m_err, e.err);
      check("fail_valid", m_fv, e.fv);
      check("first_fail_idx", m_ffi, e.ffi);
      check("pass", m_pass, e.pass);
    end
  endtask
  task automatic run_sweep(input logic [1:0] m, input res_t e);
    int n;
    mode = m;
    sb.push_back(e);
    @(negedge clk);
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    n = 1;
    while (!m_done && n < 2 * LAT) begin
      check("busy", m_busy, 1);
      check("vector", m_vec, (n - 1) / (SETTLE + 1));
      @(negedge clk);
      n++;
    end
    check("done_cycle", n, LAT);
    @(negedge clk);
    check("done_pulse", m_done, 0);
    check("busy_idle", m_busy, 0);
    score();
  endtask
  task automatic no_done(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      seen |= m_done;
    end
    check(tag, seen, 0);
  endtask
  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("reset_outs0", m_all, 0);
    sel = 1'b1;
    #1;
    check("reset_outs1", m_all, 0);
    sel = 1'b0;
    rst_n = 1'b1;
    run_sweep(2'd0, '{4'd0, 1'b0, 3'd0, 1'b1});
    run_sweep(2'd1, '{4'd8, 1'b1, 3'd0, 1'b0});
    run_sweep(2'd2, '{4'd1, 1'b1, 3'd5, 1'b0});
    run_sweep(2'd0, '{4'd0, 1'b0, 3'd0, 1'b1});
    @(negedge clk);
    abort_r = 1'b1;
    @(negedge clk);
    abort_r = 1'b0;
    check("idle_abort_pass", m_pass, 0);
    check("idle_abort_busy", m_busy, 0);
    mode = 2'd1;
    @(negedge clk);
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_abort_busy", m_busy, 1);
    abort_r = 1'b1;
    @(negedge clk);
    abort_r = 1'b0;
    check("abort_busy", m_busy, 0);
    check("abort_vec", m_vec, 0);
    check("abort_pass", m_pass, 0);
    check("abort_err", m_err, 3);
    check("abort_fv", m_fv, 1);
    check("abort_ffi", m_ffi, 0);
    no_done("abort_no_done", 30);
    start_r = 1'b1;
    abort_r = 1'b1;
    @(negedge clk);
    check("start_abort_busy", m_busy, 0);
    start_r = 1'b0;
    abort_r = 1'b0;
    @(negedge clk);
    check("start_abort_busy2", m_busy, 0);
    sb.push_back('{4'd8, 1'b1, 3'd0, 1'b0});
    start_r = 1'b1;
    @(negedge clk);
    n = 1;
    while (!m_done && n < 2 * LAT) begin
      @(negedge clk);
      n++;
    end
    check("held_done_cycle", n, LAT);
    @(negedge clk);
    check("held_idle_gap", m_busy, 0);
    score();
    @(negedge clk);
    check("held_restart", m_busy, 1);
    check("held_restart_vec", m_vec, 0);
    repeat (11) @(negedge clk);
    check("pre_reset_err", m_err, 3);
    rst_n = 1'b0;
    start_r = 1'b0;
    @(negedge clk);
    check("midsweep_reset_outs", m_all, 0);
    rst_n = 1'b1;
    no_done("reset_no_done", 30);
    sel = 1'b1;
    #1;
    f1_stuck = 1'b0;
    run_sweep(2'd0, '{4'd0, 1'b0, 3'd0, 1'b1});
    f1_stuck = 1'b1;
    run_sweep(2'd0, '{4'd1, 1'b1, 3'd7, 1'b0});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/gate_truth_sequencer.md
Name: gate_truth_sequencer

Overview:
- Sequencer that drives all 8 input combinations {A,B,C} into a 3-input combinational gate block under test.
- For each vector it waits a programmable settle time, samples F1/F2 and compares them with expected truth-table masks.
- Reports busy/done, pass, mismatch count and the first failing vector.
- Sits between board-level start/abort controls and the gate datapath; the gate itself is instantiated outside this block.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..15.
- EXP_F2, 8'h7F, expected F2 per vector; bit i is the expectation for vector i = {A,B,C} (A is MSB).
- EXP_F1, 8'h00, expected F1 per vector, same indexing.
- CHK_F1, 0, 1 = include F1 in the comparison; 0 = ignore F1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  level-sampled request to begin a sweep; acted on only in IDLE.
- abort  in  1  terminate the sweep; highest priority in every state.
- dut_a  out  1  registered gate input A (vector bit 2).
- dut_b  out  1  registered gate input B (vector bit 1).
- dut_c  out  1  registered gate input C (vector bit 0).
- dut_f1  in  1  gate output F1.
- dut_f2  in  1  gate output F2.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes normally.
- pass  out  1  1 = last completed sweep had zero mismatches.
- err_count  out  4  mismatch count for the last or current sweep, 0..8.
- fail_valid  out  1  at least one mismatch recorded in this sweep.
- first_fail_idx  out  3  vector index of the first mismatch; valid only when fail_valid=1.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. All outputs 0, including the dut vector, pass, err_count, fail_valid and first_fail_idx. Reset mid-sweep abandons the sweep with no done pulse.
- States: IDLE, SETTLE, SAMPLE, DONE. All registered, Moore outputs.
- IDLE:
  - start=1 and abort=0 at an edge: idx<=0, dut vector<=0, settle counter<=SETTLE_CYCLES-1.
  - Clears err_count, fail_valid, first_fail_idx and pass; goes to SETTLE.
  - busy=1 from the next cycle.
- SETTLE: decrements the counter each cycle; at 0, goes to SAMPLE. Each vector is therefore held for exactly SETTLE_CYCLES cycles before its sample cycle.
- SAMPLE (one cycle):
  - Mismatch = (dut_f2 != EXP_F2[idx]) | (CHK_F1 & (dut_f1 != EXP_F1[idx])).
  - On a mismatch: err_count+1. If fail_valid=0, set fail_valid=1 and first_fail_idx<=idx.
  - If idx==7, go to DONE. Otherwise idx+1, update the dut vector, reload the counter and go to SETTLE.
- DONE (one cycle): done=1, busy=0, pass<=(err_count==0 after the final sample); then IDLE.
- pass, err_count, fail_valid and first_fail_idx hold until the next accepted start.
- Latency: start sampled at edge 0 gives done high in cycle 8*(SETTLE_CYCLES+1)+1. With the default, done is high in cycle 25 and busy is high in cycles 1..24.
- Vector order is strictly 0..7. idx never wraps within a sweep.
- start while busy or in DONE: ignored; no queuing.
- abort=1 at any edge outside reset:
  - Next state IDLE, dut vector<=0, busy<=0, no done pulse, pass<=0.
  - err_count, fail_valid and first_fail_idx keep their partial values.
  - start and abort together in IDLE: abort wins and no sweep begins.
- err_count never exceeds 8, so no saturation logic is required.

Decomposition:
- Package gate_seq_pkg holds:
  - state enum (IDLE, SETTLE, SAMPLE, DONE);
  - NUM_VEC=8, IDX_W=3, CNT_W=4, ERR_W=4.
- One natural sub-module, gate_seq_settle_timer: loadable down-counter with a zero flag, CNT_W wide.
- Compare logic and FSM stay in the top module.

Test Plan:
- Gate model F2 = ~(A&B&C), defaults, start pulse at cycle 0 -> vectors 0..7 each held 3 cycles; done=1 in cycle 25 only; pass=1, err_count=0, fail_valid=0.
- Gate model F2 = A&B&C -> all 8 vectors mismatch; err_count=8, first_fail_idx=0, fail_valid=1, pass=0.
- NAND model with F2 forced to 0 on vector 5 only -> err_count=1, first_fail_idx=5, pass=0; then a second sweep with a correct model -> pass=1, err_count=0, fail_valid=0.
- abort=1 at cycle 10 of a sweep -> busy=0 and dut vector=0 from cycle 11; no done pulse; pass=0. start and abort together in IDLE -> busy stays 0.
- start held high through a whole sweep -> exactly one sweep per IDLE visit; second sweep begins the cycle after the DONE cycle. rst_n=0 at cycle 12 -> all outputs 0 next cycle, no done.
- CHK_F1=1, EXP_F1=8'h80, F1 = A&B&C model, F2 = NAND model -> pass=1. Same setup with F1 stuck at 0 -> err_count=1, first_fail_idx=7.
